// File: rtl/vtimer_scheduler.sv
// NCH virtual timers sharing one prescaler and one decrementer behind a Wishbone slave; 1-cycle ack,
// no wait states or backpressure; each prescaler tick starts a scan visiting one channel per clock.
module vtimer_scheduler #(
  parameter int NCH             = 4,
  parameter int CNTw            = 32,
  parameter int PRESCALER_WIDTH = 8,
  parameter int Dw              = 32,
  parameter int Aw              = 5,
  parameter int SELw            = 4,
  parameter int TAGw            = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [Dw-1:0]   sa_dat_i,
  input  logic [SELw-1:0] sa_sel_i,
  input  logic [Aw-1:0]   sa_addr_i,
  input  logic [TAGw-1:0] sa_tag_i,
  input  logic            sa_stb_i,
  input  logic            sa_cyc_i,
  input  logic            sa_we_i,
  output logic [Dw-1:0]   sa_dat_o,
  output logic            sa_ack_o,
  output logic            sa_err_o,
  output logic            sa_rty_o,
  output logic            irq
);

  localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int PW = PRESCALER_WIDTH;

  typedef enum logic {IDLE, SCAN} state_t;

  state_t          state, state_nx;
  logic [IW-1:0]   idx;
  logic            tick_pend, tick, visit, last, ovr_set;
  logic [PW-1:0]   div, presc;
  logic            gen, ovr;
  logic [NCH-1:0]  pending, en, per, ie;
  logic [NCH-1:0]  vis, hit, blocked, wr_ctrl, wr_reload, wr_count;
  logic [CNTw-1:0] reload [NCH];
  logic [CNTw-1:0] count  [NCH];
  logic            bus_req, wr, wr_gctrl, wr_status;
  logic [Dw-1:0]   rd_dat;
  logic            unused_inputs;

  assign sa_err_o      = 1'b0;
  assign sa_rty_o      = 1'b0;
  assign unused_inputs = ^{sa_sel_i, sa_tag_i, sa_dat_i};

  assign bus_req   = sa_stb_i & sa_cyc_i & ~sa_ack_o;
  assign wr        = bus_req & sa_we_i;
  assign wr_gctrl  = wr && (sa_addr_i == Aw'(0));
  assign wr_status = wr && (sa_addr_i == Aw'(1));

  always_comb begin
    vis       = '0;
    hit       = '0;
    blocked   = '0;
    wr_ctrl   = '0;
    wr_reload = '0;
    wr_count  = '0;
    for (int c = 0; c < NCH; c++) begin
      wr_ctrl[c]   = wr && (sa_addr_i == Aw'(4*c + 4));
      wr_reload[c] = wr && (sa_addr_i == Aw'(4*c + 5));
      wr_count[c]  = wr && (sa_addr_i == Aw'(4*c + 6));
      vis[c]       = visit && (idx == IW'(c)) && en[c];
      hit[c]       = vis[c] && (count[c] <= CNTw'(1));
      // A bus write to CTRL/COUNT wins over the scanner's update of the same channel
      blocked[c]   = wr_ctrl[c] | wr_count[c];
    end
  end

  assign tick = gen && (presc == div);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)               presc <= '0;
    else if (!gen || tick)   presc <= '0;
    else                     presc <= presc + PW'(1);
  end

  assign last = (idx == IW'(NCH - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (tick || tick_pend) state_nx = SCAN;
      SCAN:    if (last && !tick_pend) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    visit   = (state == SCAN);
    ovr_set = tick && tick_pend && !(visit && last);
  end

  // A tick landing on the last channel is held in tick_pend and starts the next scan
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx       <= '0;
      tick_pend <= 1'b0;
    end else if (!visit) begin
      idx       <= '0;
      tick_pend <= 1'b0;
    end else if (last) begin
      idx       <= '0;
      tick_pend <= tick;
    end else begin
      idx <= idx + IW'(1);
      if (tick) tick_pend <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div     <= '0;
      gen     <= 1'b0;
      pending <= '0;
      ovr     <= 1'b0;
    end else begin
      if (wr_gctrl) {gen, div} <= sa_dat_i[PW:0];
      pending <= (pending & ~({NCH{wr_status}} & sa_dat_i[NCH-1:0])) | hit;
      ovr     <= (ovr & ~(wr_status & sa_dat_i[15])) | ovr_set;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      en  <= '0;
      per <= '0;
      ie  <= '0;
      for (int c = 0; c < NCH; c++) begin
        reload[c] <= '0;
        count[c]  <= '0;
      end
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (vis[c] && !blocked[c]) begin
          if (hit[c]) begin
            if (per[c]) begin
              count[c] <= reload[c];
            end else begin
              count[c] <= '0;
              en[c]    <= 1'b0;
            end
          end else begin
            count[c] <= count[c] - CNTw'(1);
          end
        end
        if (wr_ctrl[c]) begin
          en[c]  <= sa_dat_i[0];
          per[c] <= sa_dat_i[1];
          ie[c]  <= sa_dat_i[2];
        end
        if (wr_reload[c]) reload[c] <= sa_dat_i[CNTw-1:0];
        if (wr_count[c])  count[c]  <= sa_dat_i[CNTw-1:0];
      end
    end
  end

  always_comb begin
    rd_dat = '0;
    if (sa_addr_i == Aw'(0)) begin
      rd_dat[PW-1:0] = div;
      rd_dat[PW]     = gen;
    end
    if (sa_addr_i == Aw'(1)) begin
      rd_dat[NCH-1:0] = pending;
      rd_dat[15]      = ovr;
    end
    for (int c = 0; c < NCH; c++) begin
      if (sa_addr_i == Aw'(4*c + 4)) rd_dat[2:0]      = {ie[c], per[c], en[c]};
      if (sa_addr_i == Aw'(4*c + 5)) rd_dat[CNTw-1:0] = reload[c];
      if (sa_addr_i == Aw'(4*c + 6)) rd_dat[CNTw-1:0] = count[c];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sa_ack_o <= 1'b0;
      sa_dat_o <= '0;
    end else begin
      sa_ack_o <= sa_stb_i & ~sa_ack_o;
      if (bus_req) sa_dat_o <= rd_dat;
    end
  end

  assign irq = |(pending & ie);

endmodule

// File: doc/vtimer_scheduler.md
# vtimer_scheduler

Virtual-timer scheduler that shares one prescaler and one decrement datapath among NCH independent software timers behind a Wishbone slave port. On each prescaler tick it time-multiplexes the shared decrementer across the channels, one channel per clock. It reloads or disables expired channels and collects their expiries into a single write-1-to-clear pending register that drives one interrupt line. It sits next to the general-purpose timer on the peripheral bus, for software that needs more timers than hardware instances.

## Interface

- NCH, 4: number of virtual timer channels (1..7).
- CNTw, 32: channel counter width (≤ Dw).
- PRESCALER_WIDTH, 8: prescaler divisor width.
- Dw, 32: Wishbone data width.
- Aw, 5: Wishbone address width (word address).
- SELw, 4: Wishbone select width (ignored; full-word access only).
- TAGw, 3: Wishbone tag width (ignored).

Ports:

- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- sa_dat_i  in  Dw  write data.
- sa_sel_i  in  SELw  byte select, ignored.
- sa_addr_i  in  Aw  word address.
- sa_tag_i  in  TAGw  ignored.
- sa_stb_i, sa_cyc_i, sa_we_i  in  1  strobe, cycle, write enable.
- sa_dat_o  out  Dw  registered read data.
- sa_ack_o  out  1  acknowledge.
- sa_err_o, sa_rty_o  out  1  tied 0.
- irq  out  1  level interrupt.

## Operation

**Address map**

- 0 GCTRL: [PRESCALER_WIDTH-1:0] DIV; bit PRESCALER_WIDTH GEN (global enable).
- 1 STATUS: [NCH-1:0] pending, write-1-to-clear; bit 15 OVR (overrun), sticky, W1C.
- 2, 3: reserved; writes ignored, reads return 0.
- Channel c (0..NCH-1) occupies 4*(c+1) and the next two words:
  - +0 CTRL: bit0 EN, bit1 PERIODIC, bit2 IE.
  - +1 RELOAD: reload value.
  - +2 COUNT: current count, read/write.
- Any other address: writes ignored, reads return 0.

**Prescaler**

- The prescaler counter runs only while GEN=1.
- A tick occurs when the counter equals DIV; the counter then returns to 0. One tick therefore occurs every DIV+1 clocks.
- GEN=0 holds the counter at 0.

**Scan FSM**

- States: IDLE, SCAN.
- IDLE → SCAN on a tick, or when tick_pend is set. Channel index idx is set to 0.
- In SCAN, the channel idx is visited each cycle. If its EN=1:
  - COUNT ≤ 1: expire. Set pending[idx]. If PERIODIC, load COUNT=RELOAD; otherwise set COUNT=0 and clear EN.
  - Otherwise: COUNT = COUNT-1.
- Channels with EN=0 are left unchanged.
- After idx=NCH-1: return to IDLE, or restart at idx=0 if tick_pend is set (tick_pend is then cleared).
- A tick that arrives during SCAN sets tick_pend. If tick_pend is already set, the tick is dropped and OVR is set.
- Loading COUNT=N (N ≥ 1) expires at the Nth tick. COUNT=0 with EN=1 expires at the next tick.

**Collisions**

- If a bus write to CTRL or COUNT of channel c coincides with the scanner visiting c, the bus write wins. The scanner's COUNT/EN update for c is discarded; its pending set still takes effect.
- If a STATUS W1C coincides with a pending set on the same bit, the set wins.
- Arithmetic is unsigned modulo 2^CNTw. Reload writes are truncated to CNTw.

**Interrupt**

- irq = |(pending & IE-vector), combinational from registers.

## Timing

**Reset values**

- All registers are 0: GCTRL, STATUS, CTRL, RELOAD, COUNT, prescaler, tick_pend.
- FSM = IDLE.
- sa_dat_o=0, sa_ack_o=0, irq=0.

**Bus**

- sa_ack_o <= sa_stb_i & ~sa_ack_o, giving one-cycle acknowledge latency.
- Writes take effect on the clock edge where sa_stb_i=1 and sa_ack_o=0.
- Read data is registered on that same edge and is valid while sa_ack_o=1.

**Scan**

- A tick at cycle t visits channel k at cycle t+1+k.
- pending[k] and irq are visible at t+2+k.
- A full scan takes NCH cycles. OVR cannot occur if DIV+1 ≥ NCH.

**Reset mid-scan**

- Asynchronous reset returns the block to reset values immediately. No partial state is retained.

## Test plan

1. DIV=9, GEN=1; ch0 RELOAD=3, COUNT=3, CTRL=EN|PERIODIC|IE → ch0 pending and irq rise every 30 clocks; COUNT reloads to 3; irq stays high until STATUS is written with 0x1.
2. ch1 one-shot: COUNT=2, CTRL=EN|IE, DIV=4 → one expiry 10 clocks after enable, plus scan offset 2 cycles; CTRL reads 0x4 (EN cleared); no further expiries.
3. NCH=4, DIV=0 (tick every clock) → ticks exceed scan rate; OVR=1 after second tick during scan; W1C 0x8000 clears OVR.
4. Bus writes COUNT=100 to ch2 exactly on ch2's scan cycle → COUNT reads 100, not 99; write to STATUS bit2 on the expiry cycle → pending[2] remains 1.
5. IE=0 with expiry → pending bit set, irq=0; later setting IE=1 → irq=1 next cycle.
6. Assert reset during SCAN with pending set → all reads return 0; irq=0; no expiry until reprogrammed.
